// File: rtl/cpu_pkg.sv
// Shared encodings for the store path: access sizes, FSM states and the
// alignment rule used to reject bad requests.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Size 2'b11 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational merge of a truncated store value into an existing memory word.
// Lanes the store does not touch pass through from old_word unchanged.
module store_lane_merge
  import cpu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [31:0] new_word
);

  logic [1:0] lane;
  logic       hsel;

  always_comb begin
    // Big-endian mirrors the byte lane (3-a) and flips the half select.
    lane     = BIG_ENDIAN ? ~addr_lo : addr_lo;
    hsel     = addr_lo[1] ^ BIG_ENDIAN;
    new_word = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    new_word[7:0]   = wdata[7:0];
          2'd1:    new_word[15:8]  = wdata[7:0];
          2'd2:    new_word[23:16] = wdata[7:0];
          default: new_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (hsel) new_word[31:16] = wdata[15:0];
        else      new_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: new_word = wdata;
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store unit for a word-wide RAM without byte enables: word stores write
// directly, sub-word stores read-modify-write through store_lane_merge.
module store_narrow_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       merged;

  store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .new_word (merged)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    merge_d   = merge_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          // Word stores skip the read, so the merge register holds the data now.
          merge_d = req_wdata;
          if (is_misaligned(req_size, req_addr[1:0])) state_d = ST_ERR;
          else if (req_size == SZ_WORD)                state_d = ST_WRITE;
          else                                         state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        merge_d = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr_en = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      merge_q <= merge_d;
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = merge_q;

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path immediate/data extender.
- Takes a 32-bit register value plus size (byte/half/word) and truncates it to the requested width.
- Writes the result into a word-wide data memory that has no byte enables, using read-modify-write for sub-word stores.
- Sits between the CPU store datapath and data memory. It stalls the CPU through a ready/done handshake.

Parameters:
- ADDR_W, 32, byte-address width.
- BIG_ENDIAN, 0, lane order.
  - 0: byte 0 is bits [7:0].
  - 1: byte 0 is bits [31:24].

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit idle; a request is accepted when req_valid&&req_ready.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  register value; only the low 8/16/32 bits are used.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}.
- mem_rd_en  output  1  read strobe.
- mem_rdata  input  32  read data, valid exactly 1 cycle after mem_rd_en (synchronous RAM).
- mem_wr_en  output  1  write strobe, one cycle.
- mem_wdata  output  32  merged write word.
- done  output  1  one-cycle pulse when the request completes (success or error).
- err  output  1  one-cycle pulse, coincident with done, for misaligned or illegal requests.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - req_ready=1.
  - mem_rd_en, mem_wr_en, done, err = 0.
  - mem_addr and mem_wdata = 0.
  - Request registers are cleared.
- Reset mid-operation aborts the store. No mem_wr_en is issued for it after Reset deasserts.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE:
  - req_ready=1.
  - On accept (cycle T), addr, wdata and size are registered. Inputs are ignored after T.
  - Transitions on accept:
    - Misaligned or illegal request -> ERR.
    - size=10 -> WRITE.
    - Otherwise -> READ.
- Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- READ (T+1): mem_rd_en=1, mem_addr=word address -> WAIT.
- WAIT (T+2): mem_rdata is captured into the merge register -> WRITE.
- WRITE:
  - mem_wr_en=1 for exactly one cycle with mem_addr and mem_wdata -> DONE.
  - Sub-word stores write at T+3; word stores write at T+1.
- DONE: done=1 -> IDLE.
  - req_ready returns the cycle after DONE.
  - Sub-word latency: accept to done = 4 cycles. Word: 2 cycles.
- ERR (T+1): done=1, err=1, no memory access -> IDLE.
- Merge rules (BIG_ENDIAN=0):
  - Byte: lane=addr[1:0]. Bits [8*lane+7:8*lane] = wdata[7:0]; the other 24 bits come from mem_rdata unchanged.
  - Half: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0].
  - Word: mem_wdata = wdata. No read is issued.
- BIG_ENDIAN=1: lane index is mirrored (3-lane for bytes, half select inverted).
- Upper bits of wdata are always discarded (truncation). No overflow check is performed.
- req_ready=0 in every state except IDLE. req_valid held during a busy period is not accepted until IDLE.
- mem_rd_en and mem_wr_en are never both high.

Decomposition:
- Shared package (cpu_pkg):
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding localparams.
- Natural sub-module: store_lane_merge, a combinational inputs-to-word merge function (old_word, wdata, addr[1:0], size -> new_word). It is reusable by a future load/store checker.

Test Plan:
- Byte store:
  - Stimulus: mem[0x10]=0x11223344; store byte wdata=0xFFFFFFAB, addr=0x12.
  - Required: read at T+1 and write at T+3 to address 0x10 with data 0x11AB3344; done at T+4; err=0.
- Half store:
  - Stimulus: mem[0x20]=0xDEADBEEF; store half wdata=0x0000CAFE, addr=0x22.
  - Required: write 0xCAFEBEEF.
  - Repeat at addr=0x20; required write 0xDEADCAFE.
- Word store:
  - Stimulus: wdata=0x12345678, addr=0x40.
  - Required: no mem_rd_en; mem_wr_en at T+1 with 0x12345678; done at T+2.
- Errors (each case separately):
  - Stimulus: half to addr=0x31; word to addr=0x42; size=11.
  - Required: done=err=1 at T+1; mem_rd_en and mem_wr_en stay 0; memory unchanged.
- Back-to-back and busy handling:
  - Stimulus: req_valid held high with two requests.
  - Required: the second is accepted only in the cycle req_ready reasserts; req_addr changes while busy do not affect the first write.
- Reset mid-operation:
  - Stimulus: assert Reset during the WAIT state of a byte store.
  - Required: all outputs 0 immediately, req_ready=1; no write is ever issued; the next request completes normally.
